// File: rtl/writeback_buffer_pkg.sv
// Shared widths and state encoding for the writeback buffer and its helpers.
package writeback_buffer_pkg;

   localparam int WORD_SIZE    = 32;
   localparam int BLOCK_SIZE   = 4;
   localparam int BLOCK_INDEX  = 2;
   localparam int BLOCK_ADDR_W = WORD_SIZE - BLOCK_INDEX;
   localparam int BLOCK_W      = WORD_SIZE * BLOCK_SIZE;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_WRITE = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_buffer_match.sv
// Address comparator array over the buffer entries with youngest-first priority.
// Entries are walked oldest to youngest starting at head, so a later match
// overrides an earlier one and the youngest matching entry is reported.
module wb_match #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int ADDR_W = 30
) (
   input  logic [DEPTH-1:0]  entry_valid,
   input  logic [DEPTH-1:0]  entry_mask,
   input  logic [ADDR_W-1:0] entry_addr [DEPTH],
   input  logic [PTR_W-1:0]  head,
   input  logic [ADDR_W-1:0] key,
   output logic              hit,
   output logic [PTR_W-1:0]  hit_idx
);

   logic [PTR_W-1:0] idx;

   // Scan in age order so the last hit seen is the youngest matching entry.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if (entry_valid[idx] && !entry_mask[idx] && (entry_addr[idx] == key)) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end
   end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: queues dirty victim blocks from the cache, drains them to
// memory one at a time, coalesces repeat evictions and forwards queued data
// to refills through a combinational lookup port.
module writeback_buffer
   import writeback_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BLOCK_ADDR_W-1:0] in_addr,
   input  logic [BLOCK_W-1:0]      in_block,
   input  logic [BLOCK_ADDR_W-1:0] lookup_addr,
   output logic                    lookup_hit,
   output logic [BLOCK_W-1:0]      lookup_block,
   output logic                    mem_write_enable,
   output logic [BLOCK_ADDR_W-1:0] mem_addr,
   output logic [BLOCK_W-1:0]      mem_block,
   input  logic                    mem_ack,
   output logic [PTR_W:0]          count,
   output logic                    empty
);

   logic [DEPTH-1:0]        valid_q;
   logic [BLOCK_ADDR_W-1:0] addr_q  [DEPTH];
   logic [BLOCK_W-1:0]      block_q [DEPTH];
   logic [PTR_W-1:0]        head_q;
   logic [PTR_W-1:0]        tail_q;
   logic [PTR_W:0]          count_q;
   wb_state_t               state_q;
   wb_state_t               state_d;

   logic                    full;
   logic                    push;
   logic                    pop;
   logic                    alloc;
   logic                    launch;
   logic [DEPTH-1:0]        head_mask;
   logic                    coal_hit;
   logic [PTR_W-1:0]        coal_idx;
   logic [PTR_W-1:0]        lookup_idx;

   assign full             = (count_q == (PTR_W+1)'(DEPTH));
   assign empty            = (count_q == '0);
   assign in_ready         = !full;
   assign count            = count_q;
   assign push             = in_valid && in_ready;
   assign pop              = (state_q == WB_WRITE) && mem_ack;
   assign alloc            = push && !coal_hit;
   assign mem_write_enable = (state_q == WB_WRITE);

   // Hide the head from coalescing only while memory is being written from it.
   always_comb begin
      head_mask = '0;
      if (state_q == WB_WRITE) begin
         head_mask = DEPTH'(1) << head_q;
      end
   end

   wb_match #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .ADDR_W (BLOCK_ADDR_W)
   ) u_lookup_match (
      .entry_valid (valid_q),
      .entry_mask  ('0),
      .entry_addr  (addr_q),
      .head        (head_q),
      .key         (lookup_addr),
      .hit         (lookup_hit),
      .hit_idx     (lookup_idx)
   );

   wb_match #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .ADDR_W (BLOCK_ADDR_W)
   ) u_coalesce_match (
      .entry_valid (valid_q),
      .entry_mask  (head_mask),
      .entry_addr  (addr_q),
      .head        (head_q),
      .key         (in_addr),
      .hit         (coal_hit),
      .hit_idx     (coal_idx)
   );

   assign lookup_block = lookup_hit ? block_q[lookup_idx] : '0;

   // Entry storage: coalesce in place, allocate at tail, retire head on ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            block_q[i] <= '0;
         end
      end else begin
         if (push) begin
            if (coal_hit) begin
               block_q[coal_idx] <= in_block;
            end else begin
               valid_q[tail_q] <= 1'b1;
               addr_q[tail_q]  <= in_addr;
               block_q[tail_q] <= in_block;
            end
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
         end
      end
   end

   // Circular pointers and occupancy; a coalesced push does not change either.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc) begin
            tail_q <= tail_q + 1'b1;
         end
         if (pop) begin
            head_q <= head_q + 1'b1;
         end
         case ({alloc, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Drain state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Launch a write from IDLE when occupied; wait for ack in WRITE, then bubble.
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (!empty) begin
               state_d = WB_WRITE;
               launch  = 1'b1;
            end
         end
         WB_WRITE: begin
            if (mem_ack) begin
               state_d = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // Capture the head onto the memory port at launch; a same-edge coalesce
   // into that head forwards the newer block so memory never sees stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_block <= '0;
      end else if (launch) begin
         mem_addr <= addr_q[head_q];
         if (push && coal_hit && (coal_idx == head_q)) begin
            mem_block <= in_block;
         end else begin
            mem_block <= block_q[head_q];
         end
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomised scoreboard bench for writeback_buffer against a queue-based model.
module tb_writeback_buffer;
   import writeback_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic                    clk;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [BLOCK_ADDR_W-1:0] in_addr;
   logic [BLOCK_W-1:0]      in_block;
   logic [BLOCK_ADDR_W-1:0] lookup_addr;
   logic                    lookup_hit;
   logic [BLOCK_W-1:0]      lookup_block;
   logic                    mem_write_enable;
   logic [BLOCK_ADDR_W-1:0] mem_addr;
   logic [BLOCK_W-1:0]      mem_block;
   logic                    mem_ack;
   logic [PTR_W:0]          count;
   logic                    empty;

   writeback_buffer #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_addr          (in_addr),
      .in_block         (in_block),
      .lookup_addr      (lookup_addr),
      .lookup_hit       (lookup_hit),
      .lookup_block     (lookup_block),
      .mem_write_enable (mem_write_enable),
      .mem_addr         (mem_addr),
      .mem_block        (mem_block),
      .mem_ack          (mem_ack),
      .count            (count),
      .empty            (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [BLOCK_ADDR_W-1:0] addr;
      logic [BLOCK_W-1:0]      blk;
   } ent_t;

   // Reference model: queue contents in FIFO order, in-flight flag, expected writes.
   ent_t mq[$];
   ent_t exp_q[$];
   bit   m_inflight;
   int   compared;
   int   mismatched;

   logic                    prev_we;
   logic [BLOCK_ADDR_W-1:0] held_addr;
   logic [BLOCK_W-1:0]      held_block;

   task automatic check(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_lookup(input logic [BLOCK_ADDR_W-1:0] a, output bit hit, output logic [BLOCK_W-1:0] blk);
      hit = 1'b0;
      blk = '0;
      foreach (mq[i]) begin
         if (mq[i].addr == a) begin
            hit = 1'b1;
            blk = mq[i].blk;
         end
      end
   endfunction

   // One clock edge of the buffer's rules applied to the model.
   task automatic model_step(input bit v, input logic [BLOCK_ADDR_W-1:0] a, input logic [BLOCK_W-1:0] b, input bit ack);
      bit was_empty;
      bit is_full;
      bit do_pop;
      int found;
      ent_t e;
      was_empty = (mq.size() == 0);
      is_full   = (mq.size() == DEPTH);
      do_pop    = m_inflight && ack;
      found     = -1;
      if (v && !is_full) begin
         for (int i = (m_inflight ? 1 : 0); i < mq.size(); i++) begin
            if (mq[i].addr == a) found = i;
         end
         if (found >= 0) begin
            mq[found].blk = b;
         end else begin
            e.addr = a;
            e.blk  = b;
            mq.push_back(e);
         end
      end
      if (do_pop) begin
         void'(mq.pop_front());
         m_inflight = 1'b0;
      end else if (!m_inflight && !was_empty) begin
         m_inflight = 1'b1;
         exp_q.push_back(mq[0]);
      end
   endtask

   task automatic check_output();
      bit                 hit;
      logic [BLOCK_W-1:0] blk;
      model_lookup(lookup_addr, hit, blk);
      check("count", BLOCK_W'(count), BLOCK_W'(mq.size()));
      check("empty", BLOCK_W'(empty), BLOCK_W'(mq.size() == 0));
      check("in_ready", BLOCK_W'(in_ready), BLOCK_W'(mq.size() != DEPTH));
      check("lookup_hit", BLOCK_W'(lookup_hit), BLOCK_W'(hit));
      check("lookup_block", lookup_block, blk);
   endtask

   // Called 2 time units after a rising edge; drives one cycle of inputs.
   task automatic apply_stimulus(input bit v, input logic [BLOCK_ADDR_W-1:0] a, input logic [BLOCK_W-1:0] b,
                                 input bit ack, input logic [BLOCK_ADDR_W-1:0] la);
      in_valid    = v;
      in_addr     = a;
      in_block    = b;
      mem_ack     = ack;
      lookup_addr = la;
      #1;
      check_output();
      @(posedge clk);
      model_step(v, a, b, ack);
      #2;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && mq.size() != 0; i++) begin
         apply_stimulus(1'b0, '0, '0, 1'b1, '0);
      end
      check(name, BLOCK_W'(count), '0);
   endtask

   // Memory-side monitor: every new request must match the next expected write,
   // and the request must stay stable until it is acknowledged.
   initial begin
      ent_t e;
      prev_we = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            check("mem_write_enable", BLOCK_W'(mem_write_enable), BLOCK_W'(m_inflight));
            if (mem_write_enable) begin
               if (!prev_we) begin
                  if (exp_q.size() == 0) begin
                     compared++;
                     mismatched++;
                     $display("[TB] FAIL unexpected_write: actual addr %0h required no write", mem_addr);
                  end else begin
                     e = exp_q.pop_front();
                     check("mem_addr", BLOCK_W'(mem_addr), BLOCK_W'(e.addr));
                     check("mem_block", mem_block, e.blk);
                  end
                  held_addr  = mem_addr;
                  held_block = mem_block;
               end else begin
                  check("mem_addr_stable", BLOCK_W'(mem_addr), BLOCK_W'(held_addr));
                  check("mem_block_stable", mem_block, held_block);
               end
            end
         end
         prev_we = mem_write_enable;
      end
   end

   logic [BLOCK_W-1:0] data_a;
   logic [BLOCK_W-1:0] data_b;

   // Directed scenarios followed by randomised traffic.
   initial begin
      compared    = 0;
      mismatched  = 0;
      m_inflight  = 1'b0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_addr     = '0;
      in_block    = '0;
      mem_ack     = 1'b0;
      lookup_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_we", BLOCK_W'(mem_write_enable), '0);
      check("reset_mem_addr", BLOCK_W'(mem_addr), '0);
      check("reset_mem_block", mem_block, '0);
      check_output();
      #1;
      rst = 1'b0;

      $display("[TB] single eviction");
      data_a = 128'h11112222_33334444_55556666_77778888;
      apply_stimulus(1'b1, 30'h10, data_a, 1'b0, 30'h10);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h10);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h10);
      apply_stimulus(1'b0, '0, '0, 1'b1, 30'h10);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h10);
      check("single_count", BLOCK_W'(count), '0);

      $display("[TB] fill and back-pressure");
      for (int i = 1; i <= 5; i++) begin
         apply_stimulus(1'b1, 30'(i), {4{$urandom}}, 1'b0, 30'(i));
      end
      check("full_count", BLOCK_W'(count), BLOCK_W'(4));
      check("full_ready", BLOCK_W'(in_ready), '0);
      drain("fill_drain");

      $display("[TB] coalesce");
      data_a = {$urandom, $urandom, $urandom, $urandom};
      data_b = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(1'b1, 30'h30, {4{$urandom}}, 1'b0, 30'h20);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h20);
      apply_stimulus(1'b1, 30'h20, data_a, 1'b0, 30'h20);
      apply_stimulus(1'b1, 30'h20, data_b, 1'b0, 30'h20);
      check("coalesce_count", BLOCK_W'(count), BLOCK_W'(2));
      apply_stimulus(1'b1, 30'h30, {4{$urandom}}, 1'b0, 30'h30);
      check("inflight_alloc_count", BLOCK_W'(count), BLOCK_W'(3));
      drain("coalesce_drain");

      $display("[TB] lookup forwarding");
      data_a = {$urandom, $urandom, $urandom, $urandom};
      data_b = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(1'b1, 30'h40, data_a, 1'b0, 30'h40);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h40);
      apply_stimulus(1'b1, 30'h40, data_b, 1'b0, 30'h40);
      lookup_addr = 30'h40;
      #1;
      check("fwd_hit", BLOCK_W'(lookup_hit), BLOCK_W'(1));
      check("fwd_block", lookup_block, data_b);
      lookup_addr = 30'h41;
      #1;
      check("fwd_miss_hit", BLOCK_W'(lookup_hit), '0);
      check("fwd_miss_block", lookup_block, '0);
      #1;
      check("fwd_count", BLOCK_W'(count), BLOCK_W'(2));
      @(posedge clk);
      model_step(1'b0, in_addr, in_block, 1'b0);
      #2;
      drain("lookup_drain");

      $display("[TB] reset during write");
      apply_stimulus(1'b1, 30'h60, {4{$urandom}}, 1'b0, 30'h60);
      apply_stimulus(1'b0, '0, '0, 1'b0, 30'h60);
      check("pre_reset_we", BLOCK_W'(mem_write_enable), BLOCK_W'(1));
      rst = 1'b1;
      #1;
      check("midreset_we", BLOCK_W'(mem_write_enable), '0);
      check("midreset_count", BLOCK_W'(count), '0);
      check("midreset_empty", BLOCK_W'(empty), BLOCK_W'(1));
      check("midreset_ready", BLOCK_W'(in_ready), BLOCK_W'(1));
      check("midreset_hit", BLOCK_W'(lookup_hit), '0);
      mq.delete();
      exp_q.delete();
      m_inflight = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         apply_stimulus($urandom_range(0, 1) == 1,
                        30'h50 + 30'($urandom_range(0, 5)),
                        {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(0, 99) < 40,
                        30'h50 + 30'($urandom_range(0, 6)));
      end
      drain("final_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Sits between data_cache and data_memory on the eviction path.
- Accepts dirty victim blocks from the cache and queues them in a small FIFO.
- Drains the queue to memory one block at a time using a write/ack handshake.
- Exposes a combinational lookup port so a refill that misses in the cache can take a block still waiting here, instead of stale memory data.

Parameters:
- WORD_SIZE, 32, bits per word (shared value).
- BLOCK_SIZE, 4, words per block (shared value).
- BLOCK_INDEX, 2, log2(BLOCK_SIZE) (shared value).
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  cache presents an evicted dirty block
- in_ready  out  1  buffer can accept; equals !full
- in_addr  in  WORD_SIZE-BLOCK_INDEX  block address (ptr >> BLOCK_INDEX)
- in_block  in  WORD_SIZE*BLOCK_SIZE  block data; word 0 in the MSBs, as in the cache
- lookup_addr  in  WORD_SIZE-BLOCK_INDEX  refill block address
- lookup_hit  out  1  a valid entry matches lookup_addr
- lookup_block  out  WORD_SIZE*BLOCK_SIZE  data of the youngest matching entry; 0 when no hit
- mem_write_enable  out  1  write request to memory
- mem_addr  out  WORD_SIZE-BLOCK_INDEX  head entry address
- mem_block  out  WORD_SIZE*BLOCK_SIZE  head entry data
- mem_ack  in  1  memory has accepted the write this cycle
- count  out  PTR_W+1  number of occupied entries
- empty  out  1  count==0

Behaviour:
- Reset (async, any time):
  - All entry valid bits, pointers and count clear; state goes to IDLE.
  - Outputs: mem_write_enable=0, mem_addr=0, mem_block=0, count=0, empty=1, in_ready=1, lookup_hit=0.
  - A write that is in flight is abandoned.
- Storage:
  - Circular FIFO with head/tail pointers that wrap modulo DEPTH.
  - Each entry holds valid, addr and block.
- Push (in_valid && in_ready at posedge):
  - Coalesce case: if a valid entry other than the in-flight head matches in_addr, overwrite its block in place. count is unchanged and FIFO order is unchanged.
  - Otherwise write the tail entry and advance tail; count+1.
  - The in-flight head (state WRITE) is never modified; a push matching it allocates a new entry.
- in_ready = !full, derived from registered count. There is no same-cycle push-on-pop when full; the producer must hold in_valid.
- State machine (IDLE, WRITE):
  - IDLE: if !empty, register head addr/data onto mem_addr/mem_block, assert mem_write_enable, go to WRITE.
  - WRITE: hold mem_write_enable and all mem_* outputs stable until mem_ack.
  - On mem_ack: invalidate the head, advance head, count-1, deassert mem_write_enable, return to IDLE.
  - The IDLE cycle after an ack is a mandatory bubble, so the minimum is 2 cycles per block.
  - mem_ack in IDLE is ignored.
- Latency: a push into an empty buffer at edge N gives mem_write_enable=1 after edge N+1.
- Simultaneous push and pop in the same edge: both take effect; count stays unchanged.
- Lookup (combinational):
  - Covers all valid entries, including the in-flight head.
  - The youngest match wins.
  - A same-cycle push is not visible until the next cycle.
- Full (count==DEPTH): in_ready=0, pushes are ignored, coalescing is blocked.
- Empty: state stays IDLE, mem_write_enable=0.

Decomposition:
- Shared package/include:
  - WORD_SIZE, BLOCK_SIZE, BLOCK_INDEX.
  - A derived BLOCK_ADDR_W = WORD_SIZE-BLOCK_INDEX.
  - The state encoding constants WB_IDLE and WB_WRITE.
- One natural sub-module, wb_match: a parameterised comparator array plus youngest-first priority select. The top level instantiates it twice:
  - once for the lookup port;
  - once for coalescing, with the in-flight head masked out.

Test Plan:
- Reset mid-WRITE: assert rst while mem_write_enable=1 -> mem_write_enable drops immediately; count=0, empty=1, in_ready=1.
- Single eviction: push addr 0x10, block 0x11112222_33334444_55556666_77778888; mem_ack one cycle after request -> mem_addr=0x10 with that data; count returns to 0; request spans 2 cycles.
- Fill and back-pressure (DEPTH=4, mem_ack held 0):
  - Push 0x1..0x4 -> count=4, in_ready=0; a fifth push of 0x5 is dropped.
  - Release ack -> writes appear in order 0x1,0x2,0x3,0x4, with one IDLE bubble between each.
- Coalesce:
  - Queue 0x20 (data A) behind an in-flight 0x30, then push 0x20 (data B) -> count unchanged; memory later receives 0x20 with B only.
  - Push 0x30 while 0x30 is in flight -> new entry; count+1.
- Lookup forwarding:
  - Entries 0x40 (A) at the in-flight head and 0x40 (B) younger -> lookup_addr=0x40 gives lookup_hit=1, lookup_block=B.
  - lookup_addr=0x41 gives lookup_hit=0, lookup_block=0.
- Wrap-around: 10 push/ack cycles with interleaved simultaneous push+ack -> pointers wrap past DEPTH; memory write order matches push order; count never exceeds 4.
